cmd_frame_decoder: RTL and testbench

- Write-side front end for the five-way command FIFO array (TC/HK/SD/DI/PF).
- Takes the raw byte stream from the UART receiver and hunts for sync 0xEB 0x90, then decodes the type byte.
- Drives one-hot `cmd`, `wen` and `din` so that each command frame lands whole in its FIFO.
- Discards frames whose target FIFO is full, and pads truncated frames so FIFO frame alignment is never lost.

---
 rtl/cmd_pkg.sv | 62 ++++++
 rtl/frame_timeout.sv | 30 +++
 rtl/cmd_frame_decoder.sv | 148 ++++++++++++++
 tb/tb_cmd_frame_decoder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared constants, state encoding and type-code decoder for the command frame front end.
package cmd_pkg;

   localparam int unsigned CMD_W = 5;
   localparam int unsigned REM_W = 6;
   localparam int unsigned CHK_W = 8;
   localparam int unsigned TMO_W = 16;

   localparam logic [7:0] CODE_TC = 8'h01;
   localparam logic [7:0] CODE_HK = 8'h02;
   localparam logic [7:0] CODE_SD = 8'h03;
   localparam logic [7:0] CODE_DI = 8'h04;
   localparam logic [7:0] CODE_PF = 8'h05;

   // Forwarded bytes per frame, type byte and checksum included
   localparam logic [REM_W-1:0] LEN_TC = 6'd13;
   localparam logic [REM_W-1:0] LEN_HK = 6'd9;
   localparam logic [REM_W-1:0] LEN_SD = 6'd9;
   localparam logic [REM_W-1:0] LEN_DI = 6'd25;
   localparam logic [REM_W-1:0] LEN_PF = 6'd53;

   localparam int unsigned IDX_TC = 0;
   localparam int unsigned IDX_HK = 1;
   localparam int unsigned IDX_SD = 2;
   localparam int unsigned IDX_DI = 3;
   localparam int unsigned IDX_PF = 4;

   localparam logic [7:0] SYNC_HI = 8'hEB;
   localparam logic [7:0] SYNC_LO = 8'h90;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC2,
      ST_TYPE,
      ST_CHECK,
      ST_PAYLOAD,
      ST_DROP,
      ST_PAD
   } state_t;

   typedef struct packed {
      logic             known;
      logic [CMD_W-1:0] onehot;
      logic [REM_W-1:0] len;
   } type_info_t;

   // Map a type byte to its FIFO select and frame length
   function automatic type_info_t decode_type(input logic [7:0] code);
      type_info_t t;
      t = '0;
      case (code)
         CODE_TC: begin t.known = 1'b1; t.onehot[IDX_TC] = 1'b1; t.len = LEN_TC; end
         CODE_HK: begin t.known = 1'b1; t.onehot[IDX_HK] = 1'b1; t.len = LEN_HK; end
         CODE_SD: begin t.known = 1'b1; t.onehot[IDX_SD] = 1'b1; t.len = LEN_SD; end
         CODE_DI: begin t.known = 1'b1; t.onehot[IDX_DI] = 1'b1; t.len = LEN_DI; end
         CODE_PF: begin t.known = 1'b1; t.onehot[IDX_PF] = 1'b1; t.len = LEN_PF; end
         default: t = '0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/frame_timeout.sv
// Idle-gap counter: cleared by each received byte or when disabled, flags expiry on the TIMEOUT-th idle cycle.
module frame_timeout #(
   parameter int unsigned TIMEOUT = 20000,
   parameter int unsigned CNT_W   = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire_c
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   // Count idle cycles while enabled; saturate at the expiry value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr || !en) begin
         cnt <= '0;
      end else if (cnt != LAST) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expire_c = en && !clr && (cnt == LAST);

endmodule

// File: rtl/cmd_frame_decoder.sv
// Sync hunt, type decode and FIFO write sequencing for the five-way command FIFO array.
module cmd_frame_decoder
   import cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT = 20000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   input  logic             full,
   output logic [CMD_W-1:0] cmd,
   output logic             wen,
   output logic [7:0]       din,
   output logic             frame_done,
   output logic             chk_err,
   output logic             tmo_err,
   output logic             drop,
   output logic             type_err
);

   state_t           state;
   logic [REM_W-1:0] rem;
   logic [CHK_W-1:0] chk;
   logic [7:0]       type_byte;
   type_info_t       tinfo_c;
   logic [CHK_W-1:0] chk_next_c;
   logic             tmo_en_c;
   logic             tmo_exp_c;

   assign tinfo_c    = decode_type(rx_data);
   assign chk_next_c = chk ^ rx_data;
   assign tmo_en_c   = (state == ST_SYNC2) || (state == ST_TYPE) ||
                       (state == ST_PAYLOAD) || (state == ST_DROP);

   frame_timeout #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (TMO_W)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clr      (rx_valid),
      .en       (tmo_en_c),
      .expire_c (tmo_exp_c)
   );

   // Frame state machine with registered FIFO-side outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         cmd        <= '0;
         wen        <= 1'b0;
         din        <= '0;
         frame_done <= 1'b0;
         chk_err    <= 1'b0;
         tmo_err    <= 1'b0;
         drop       <= 1'b0;
         type_err   <= 1'b0;
         rem        <= '0;
         chk        <= '0;
         type_byte  <= '0;
      end else begin
         wen        <= 1'b0;
         frame_done <= 1'b0;
         chk_err    <= 1'b0;
         tmo_err    <= 1'b0;
         drop       <= 1'b0;
         type_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rx_valid && (rx_data == SYNC_HI)) state <= ST_SYNC2;
            end
            ST_SYNC2: begin
               if (rx_valid) begin
                  if (rx_data == SYNC_LO)      state <= ST_TYPE;
                  else if (rx_data != SYNC_HI) state <= ST_IDLE;
               end else if (tmo_exp_c) begin
                  state <= ST_IDLE;
               end
            end
            ST_TYPE: begin
               if (rx_valid) begin
                  if (tinfo_c.known) begin
                     cmd       <= tinfo_c.onehot;
                     type_byte <= rx_data;
                     rem       <= tinfo_c.len - REM_W'(1);
                     state     <= ST_CHECK;
                  end else begin
                     type_err <= 1'b1;
                     state    <= ST_IDLE;
                  end
               end else if (tmo_exp_c) begin
                  state <= ST_IDLE;
               end
            end
            // cmd is now driving the array, so full refers to the target FIFO
            ST_CHECK: begin
               if (full) begin
                  drop  <= 1'b1;
                  state <= ST_DROP;
               end else begin
                  wen   <= 1'b1;
                  din   <= type_byte;
                  chk   <= type_byte;
                  state <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               if (rx_valid) begin
                  wen <= 1'b1;
                  din <= rx_data;
                  chk <= chk_next_c;
                  rem <= rem - REM_W'(1);
                  if (rem == REM_W'(1)) begin
                     frame_done <= 1'b1;
                     chk_err    <= (chk_next_c != '0);
                     state      <= ST_IDLE;
                  end
               end else if (tmo_exp_c) begin
                  tmo_err <= 1'b1;
                  state   <= ST_PAD;
               end
            end
            ST_DROP: begin
               if (rx_valid) begin
                  rem <= rem - REM_W'(1);
                  if (rem == REM_W'(1)) state <= ST_IDLE;
               end else if (tmo_exp_c) begin
                  state <= ST_IDLE;
               end
            end
            // Zero-fill the rest of a truncated frame to keep FIFO framing intact
            ST_PAD: begin
               wen <= 1'b1;
               din <= '0;
               rem <= rem - REM_W'(1);
               if (rem == REM_W'(1)) begin
                  frame_done <= 1'b1;
                  chk_err    <= 1'b1;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Directed bench for cmd_frame_decoder: frame vector table plus timeout, sync-hunt and reset sequences.
module tb_cmd_frame_decoder;

   localparam int unsigned TMO = 20000;

   logic       clk;
   logic       rst;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       full;
   logic [4:0] cmd;
   logic       wen;
   logic [7:0] din;
   logic       frame_done;
   logic       chk_err;
   logic       tmo_err;
   logic       drop;
   logic       type_err;

   logic [4:0] full_mask;

   cmd_frame_decoder #(.TIMEOUT(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .full       (full),
      .cmd        (cmd),
      .wen        (wen),
      .din        (din),
      .frame_done (frame_done),
      .chk_err    (chk_err),
      .tmo_err    (tmo_err),
      .drop       (drop),
      .type_err   (type_err)
   );

   // Array model: full flag of whichever FIFO cmd currently selects
   assign full = |(cmd & full_mask);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor, sampled on the falling edge
   logic [7:0] wdin[$];
   int         wcyc[$];
   int         rcyc[$];
   int         fd_n = 0, ce_n = 0, ce_orphan = 0, tmo_n = 0, drop_n = 0, te_n = 0;
   int         tmo_cyc = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (wen) begin
            wdin.push_back(din);
            wcyc.push_back(cyc);
         end
         if (frame_done) fd_n++;
         if (chk_err) ce_n++;
         if (chk_err && !frame_done) ce_orphan++;
         if (tmo_err) begin tmo_n++; tmo_cyc = cyc; end
         if (drop) drop_n++;
         if (type_err) te_n++;
      end
   end

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_valid = 1'b1;
      rx_data  = b;
      rcyc.push_back(cyc);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      wait_cycles(1);
   endtask

   // Frame bytes after the sync word, built deterministically
   logic [7:0] fb[$];

   task automatic build_frame(input logic [7:0] code, input int n, input bit bad);
      logic [7:0] x;
      logic [7:0] b;
      fb.delete();
      fb.push_back(code);
      x = code;
      for (int k = 1; k < n - 1; k++) begin
         b = 8'((int'(code) * 16) + (k * 7));
         if (code == 8'h01 && k == 1) b = 8'hEB;
         if (code == 8'h01 && k == 2) b = 8'h90;
         fb.push_back(b);
         x = x ^ b;
      end
      if (n > 1) fb.push_back(bad ? (x ^ 8'h5A) : x);
   endtask

   task automatic send_sync_and(input int count);
      send_byte(8'hEB);
      send_byte(8'h90);
      for (int k = 0; k < count; k++) send_byte(fb[k]);
   endtask

   function automatic int din_mismatches(input int base, input int n);
      int bad = 0;
      for (int k = 0; k < n; k++) begin
         if (base + k >= wdin.size()) bad++;
         else if (wdin[base + k] !== fb[k]) bad++;
      end
      return bad;
   endfunction

   typedef struct {
      logic [7:0] code;
      int         n_len;
      bit         bad;
      logic [4:0] fmask;
      logic [4:0] e_cmd;
      int         e_wr;
      int         e_fd;
      int         e_ce;
      int         e_drop;
      int         e_te;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int w0, r0, fd0, ce0, tm0, dr0, te0, bad, d;
      logic [31:0] outs;

      vecs[0] = '{8'h01, 13, 1'b0, 5'b00000, 5'b00001, 13, 1, 0, 0, 0};
      vecs[1] = '{8'h05, 53, 1'b1, 5'b00000, 5'b10000, 53, 1, 1, 0, 0};
      vecs[2] = '{8'h02,  9, 1'b0, 5'b00010, 5'b00010,  0, 0, 0, 1, 0};
      vecs[3] = '{8'h03,  9, 1'b0, 5'b00010, 5'b00100,  9, 1, 0, 0, 0};
      vecs[4] = '{8'h04, 25, 1'b0, 5'b00000, 5'b01000, 25, 1, 0, 0, 0};
      vecs[5] = '{8'h07,  1, 1'b0, 5'b00000, 5'b01000,  0, 0, 0, 0, 1};

      rst       = 1'b1;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      full_mask = 5'b00000;
      wait_cycles(2);
      @(negedge clk);
      outs = {19'd0, cmd, wen, din, frame_done, chk_err, tmo_err, drop, type_err};
      check("reset_outputs", outs, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_cycles(2);

      // Table-driven frames
      for (int i = 0; i < 6; i++) begin
         full_mask = vecs[i].fmask;
         build_frame(vecs[i].code, vecs[i].n_len, vecs[i].bad);
         w0 = wdin.size(); r0 = rcyc.size();
         fd0 = fd_n; ce0 = ce_n; dr0 = drop_n; te0 = te_n;
         send_sync_and(vecs[i].n_len);
         wait_cycles(6);
         check($sformatf("v%0d_cmd", i), 32'(cmd), 32'(vecs[i].e_cmd));
         check($sformatf("v%0d_writes", i), 32'(wdin.size() - w0), 32'(vecs[i].e_wr));
         check($sformatf("v%0d_din_seq", i), 32'(din_mismatches(w0, vecs[i].e_wr)), 32'd0);
         check($sformatf("v%0d_frame_done", i), 32'(fd_n - fd0), 32'(vecs[i].e_fd));
         check($sformatf("v%0d_chk_err", i), 32'(ce_n - ce0), 32'(vecs[i].e_ce));
         check($sformatf("v%0d_drop", i), 32'(drop_n - dr0), 32'(vecs[i].e_drop));
         check($sformatf("v%0d_type_err", i), 32'(te_n - te0), 32'(vecs[i].e_te));
         if (i == 0) begin
            d = (wcyc.size() > w0) ? wcyc[w0] - rcyc[r0 + 2] : -1;
            check("type_byte_latency", 32'(d), 32'd2);
            d = (wcyc.size() > w0 + 1) ? wcyc[w0 + 1] - rcyc[r0 + 3] : -1;
            check("payload_latency", 32'(d), 32'd1);
         end
      end
      full_mask = 5'b00000;

      // DI frame truncated after 10 forwarded bytes
      build_frame(8'h04, 25, 1'b0);
      w0 = wdin.size(); r0 = rcyc.size();
      fd0 = fd_n; ce0 = ce_n; tm0 = tmo_n;
      send_sync_and(10);
      begin
         int budget = TMO + 100;
         while (tmo_n == tm0 && budget > 0) begin
            @(posedge clk);
            budget--;
         end
      end
      check("tmo_seen", 32'(tmo_n - tm0), 32'd1);
      d = tmo_cyc - rcyc[rcyc.size() - 1];
      check("tmo_delay_window", 32'(d >= int'(TMO) && d <= int'(TMO) + 2), 32'd1);
      wait_cycles(25);
      check("tmo_writes", 32'(wdin.size() - w0), 32'd25);
      check("tmo_head_din", 32'(din_mismatches(w0, 10)), 32'd0);
      bad = 0;
      for (int k = 10; k < 25; k++) begin
         if (w0 + k >= wdin.size()) bad++;
         else begin
            if (wdin[w0 + k] !== 8'h00) bad++;
            if (k > 10 && wcyc[w0 + k] - wcyc[w0 + k - 1] != 1) bad++;
         end
      end
      check("tmo_pad_zero_consec", 32'(bad), 32'd0);
      check("tmo_frame_done", 32'(fd_n - fd0), 32'd1);
      check("tmo_chk_err", 32'(ce_n - ce0), 32'd1);
      check("tmo_single_pulse", 32'(tmo_n - tm0), 32'd1);

      // Sync hunt through 55 EB EB 90 then HK frame
      build_frame(8'h02, 9, 1'b0);
      w0 = wdin.size(); fd0 = fd_n; ce0 = ce_n;
      send_byte(8'h55);
      send_byte(8'hEB);
      send_sync_and(9);
      wait_cycles(6);
      check("hunt_cmd", 32'(cmd), 32'(5'b00010));
      check("hunt_writes", 32'(wdin.size() - w0), 32'd9);
      check("hunt_din_seq", 32'(din_mismatches(w0, 9)), 32'd0);
      check("hunt_frame_done", 32'(fd_n - fd0), 32'd1);
      check("hunt_chk_err", 32'(ce_n - ce0), 32'd0);

      // Unknown type right after keeps cmd
      w0 = wdin.size(); te0 = te_n;
      send_byte(8'hEB);
      send_byte(8'h90);
      send_byte(8'h07);
      wait_cycles(6);
      check("unk_type_err", 32'(te_n - te0), 32'd1);
      check("unk_cmd_held", 32'(cmd), 32'(5'b00010));
      check("unk_writes", 32'(wdin.size() - w0), 32'd0);

      // Reset in the middle of an SD payload
      build_frame(8'h03, 9, 1'b0);
      send_sync_and(4);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      outs = {19'd0, cmd, wen, din, frame_done, chk_err, tmo_err, drop, type_err};
      check("midframe_reset_outputs", outs, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_cycles(2);
      build_frame(8'h01, 13, 1'b0);
      w0 = wdin.size(); fd0 = fd_n; ce0 = ce_n;
      send_sync_and(13);
      wait_cycles(6);
      check("post_reset_cmd", 32'(cmd), 32'(5'b00001));
      check("post_reset_writes", 32'(wdin.size() - w0), 32'd13);
      check("post_reset_din_seq", 32'(din_mismatches(w0, 13)), 32'd0);
      check("post_reset_frame_done", 32'(fd_n - fd0), 32'd1);
      check("post_reset_chk_err", 32'(ce_n - ce0), 32'd0);

      check("chk_err_without_frame_done", 32'(ce_orphan), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
